// File: rtl/riscv_dcache_wb_buffer.sv
// Write-back buffer between the D-cache and the line-granular DRAM port.
// Queues evicted dirty lines, drains them in FIFO order, and serves refills that hit queued lines.
module riscv_dcache_wb_buffer #(
    parameter int AWIDTH = 23,
    parameter int DWIDTH = 128,
    parameter int DEPTH  = 4
) (
    input  logic              i_riscv_wbuf_clk,
    input  logic              i_riscv_wbuf_rst,
    input  logic              i_riscv_wbuf_push,
    input  logic [AWIDTH-1:0] i_riscv_wbuf_push_addr,
    input  logic [DWIDTH-1:0] i_riscv_wbuf_push_data,
    output logic              o_riscv_wbuf_full,
    output logic              o_riscv_wbuf_empty,
    input  logic              i_riscv_wbuf_rd_req,
    input  logic [AWIDTH-1:0] i_riscv_wbuf_rd_addr,
    output logic [DWIDTH-1:0] o_riscv_wbuf_rd_data,
    output logic              o_riscv_wbuf_rd_done,
    output logic              o_riscv_wbuf_mem_wren,
    output logic              o_riscv_wbuf_mem_rden,
    output logic [AWIDTH-1:0] o_riscv_wbuf_mem_addr,
    output logic [DWIDTH-1:0] o_riscv_wbuf_mem_data,
    input  logic              i_riscv_wbuf_mem_ready,
    input  logic [DWIDTH-1:0] i_riscv_wbuf_mem_rdata
);

    localparam int PTRW = $clog2(DEPTH);
    localparam int CNTW = $clog2(DEPTH + 1);

    typedef enum logic [1:0] {IDLE, RD_MEM, WR_MEM, RD_DONE} state_t;

    state_t            r_state;
    state_t            w_next;
    logic [AWIDTH-1:0] r_addr_q [DEPTH];
    logic [DWIDTH-1:0] r_data_q [DEPTH];
    logic [PTRW-1:0]   r_head;
    logic [PTRW-1:0]   r_tail;
    logic [CNTW-1:0]   r_count;
    logic              w_push_ok;
    logic              w_pop;
    logic              w_hit;
    logic [DWIDTH-1:0] w_hit_data;

    assign o_riscv_wbuf_full  = (r_count == CNTW'(DEPTH));
    assign o_riscv_wbuf_empty = (r_count == '0);
    assign w_push_ok          = i_riscv_wbuf_push && !o_riscv_wbuf_full;
    assign w_pop              = (r_state == WR_MEM) && i_riscv_wbuf_mem_ready;

    // Walk oldest to newest so the last match (newest copy) wins; a same-cycle push is newer still.
    always_comb begin
        w_hit      = 1'b0;
        w_hit_data = '0;
        for (int i = 0; i < DEPTH; i++) begin
            if (CNTW'(i) < r_count && r_addr_q[r_head + PTRW'(i)] == i_riscv_wbuf_rd_addr) begin
                w_hit      = 1'b1;
                w_hit_data = r_data_q[r_head + PTRW'(i)];
            end
        end
        if (w_push_ok && i_riscv_wbuf_push_addr == i_riscv_wbuf_rd_addr) begin
            w_hit      = 1'b1;
            w_hit_data = i_riscv_wbuf_push_data;
        end
    end

    // NOTE: the entry array has no reset; validity is tracked solely by r_count, so stale contents are never observed.
    always_ff @(posedge i_riscv_wbuf_clk) begin
        if (w_push_ok) begin
            r_addr_q[r_tail] <= i_riscv_wbuf_push_addr;
            r_data_q[r_tail] <= i_riscv_wbuf_push_data;
        end
    end

    always_ff @(posedge i_riscv_wbuf_clk or posedge i_riscv_wbuf_rst) begin
        if (i_riscv_wbuf_rst) begin
            r_head  <= '0;
            r_tail  <= '0;
            r_count <= '0;
        end else begin
            if (w_push_ok) r_tail <= r_tail + PTRW'(1);
            if (w_pop)     r_head <= r_head + PTRW'(1);
            case ({w_push_ok, w_pop})
                2'b10:   r_count <= r_count + CNTW'(1);
                2'b01:   r_count <= r_count - CNTW'(1);
                default: r_count <= r_count;
            endcase
        end
    end

    always_ff @(posedge i_riscv_wbuf_clk or posedge i_riscv_wbuf_rst) begin
        if (i_riscv_wbuf_rst) r_state <= IDLE;
        else                  r_state <= w_next;
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
            IDLE: begin
                if (i_riscv_wbuf_rd_req)      w_next = w_hit ? RD_DONE : RD_MEM;
                else if (!o_riscv_wbuf_empty) w_next = WR_MEM;
            end
            RD_MEM:  if (i_riscv_wbuf_mem_ready) w_next = RD_DONE;
            WR_MEM:  if (i_riscv_wbuf_mem_ready) w_next = IDLE;
            RD_DONE: w_next = IDLE;
            default: w_next = IDLE;
        endcase
    end

    always_comb begin
        o_riscv_wbuf_mem_wren = 1'b0;
        o_riscv_wbuf_mem_rden = 1'b0;
        o_riscv_wbuf_rd_done  = 1'b0;
        case (r_state)
            RD_MEM:  o_riscv_wbuf_mem_rden = 1'b1;
            WR_MEM:  o_riscv_wbuf_mem_wren = 1'b1;
            RD_DONE: o_riscv_wbuf_rd_done  = 1'b1;
            default: ;
        endcase
    end

    // Address/data are captured at the IDLE decision and held for the whole DRAM transaction.
    always_ff @(posedge i_riscv_wbuf_clk or posedge i_riscv_wbuf_rst) begin
        if (i_riscv_wbuf_rst) begin
            o_riscv_wbuf_rd_data  <= '0;
            o_riscv_wbuf_mem_addr <= '0;
            o_riscv_wbuf_mem_data <= '0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (i_riscv_wbuf_rd_req) begin
                        if (w_hit) o_riscv_wbuf_rd_data  <= w_hit_data;
                        else       o_riscv_wbuf_mem_addr <= i_riscv_wbuf_rd_addr;
                    end else if (!o_riscv_wbuf_empty) begin
                        o_riscv_wbuf_mem_addr <= r_addr_q[r_head];
                        o_riscv_wbuf_mem_data <= r_data_q[r_head];
                    end
                end
                RD_MEM: if (i_riscv_wbuf_mem_ready) o_riscv_wbuf_rd_data <= i_riscv_wbuf_mem_rdata;
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_riscv_dcache_wb_buffer.sv
// Directed bench for riscv_dcache_wb_buffer: drain, fill/wrap, buffer hits, miss refill priority, reset abort.
module tb_riscv_dcache_wb_buffer;

    logic         clk = 1'b0;
    logic         rst;
    logic         push;
    logic [22:0]  push_addr;
    logic [127:0] push_data;
    logic         full, empty;
    logic         rd_req;
    logic [22:0]  rd_addr;
    logic [127:0] rd_data;
    logic         rd_done;
    logic         mem_wren, mem_rden;
    logic [22:0]  mem_addr;
    logic [127:0] mem_data;
    logic         mem_ready;
    logic [127:0] mem_rdata;

    int n_checks = 0;
    int n_errors = 0;

    riscv_dcache_wb_buffer dut (
        .i_riscv_wbuf_clk       (clk),
        .i_riscv_wbuf_rst       (rst),
        .i_riscv_wbuf_push      (push),
        .i_riscv_wbuf_push_addr (push_addr),
        .i_riscv_wbuf_push_data (push_data),
        .o_riscv_wbuf_full      (full),
        .o_riscv_wbuf_empty     (empty),
        .i_riscv_wbuf_rd_req    (rd_req),
        .i_riscv_wbuf_rd_addr   (rd_addr),
        .o_riscv_wbuf_rd_data   (rd_data),
        .o_riscv_wbuf_rd_done   (rd_done),
        .o_riscv_wbuf_mem_wren  (mem_wren),
        .o_riscv_wbuf_mem_rden  (mem_rden),
        .o_riscv_wbuf_mem_addr  (mem_addr),
        .o_riscv_wbuf_mem_data  (mem_data),
        .i_riscv_wbuf_mem_ready (mem_ready),
        .i_riscv_wbuf_mem_rdata (mem_rdata)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic push_line(input logic [22:0] a, input logic [127:0] d);
        push      = 1'b1;
        push_addr = a;
        push_data = d;
        tick();
        push      = 1'b0;
    endtask

    // Wait (bounded) for a drain write, check it, hold it 3 cycles, then complete it.
    task automatic drain_one(input string tag, input logic [22:0] a, input logic [127:0] d);
        int n = 0;
        while (!mem_wren && n < 40) begin
            tick();
            n++;
        end
        check({tag, " wren"}, mem_wren, 1'b1);
        check({tag, " addr"}, mem_addr, a);
        check({tag, " data"}, mem_data, d);
        check({tag, " rden"}, mem_rden, 1'b0);
        tick();
        tick();
        tick();
        check({tag, " addr hold"}, mem_addr, a);
        check({tag, " wren hold"}, mem_wren, 1'b1);
        mem_ready = 1'b1;
        tick();
        mem_ready = 1'b0;
        check({tag, " wren drop"}, mem_wren, 1'b0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog expired");
        $fatal(1, "timeout");
    end

    initial begin
        rst = 1'b1; push = 1'b0; push_addr = '0; push_data = '0;
        rd_req = 1'b0; rd_addr = '0; mem_ready = 1'b0; mem_rdata = '0;
        tick();
        tick();
        check("rst full", full, 1'b0);
        check("rst empty", empty, 1'b1);
        check("rst wren", mem_wren, 1'b0);
        check("rst rden", mem_rden, 1'b0);
        check("rst rd_done", rd_done, 1'b0);
        rst = 1'b0;
        tick();

        // Single drain
        push_line(23'h000010, {16{8'hA5}});
        check("t1 not empty", empty, 1'b0);
        drain_one("t1", 23'h000010, {16{8'hA5}});
        check("t1 empty", empty, 1'b1);

        // Fill with DRAM stalled, overflow push dropped, drain in order with pointer wrap
        for (int i = 1; i <= 4; i++) push_line(23'(i), {4{32'hD000_0000 | i}});
        check("t2 full", full, 1'b1);
        push_line(23'h5, {4{32'hDEAD_0005}});
        check("t2 full after 5th", full, 1'b1);
        for (int i = 1; i <= 4; i++) drain_one($sformatf("t2 e%0d", i), 23'(i), {4{32'hD000_0000 | i}});
        check("t2 empty", empty, 1'b1);
        tick();
        tick();
        check("t2 no 5th drain", mem_wren, 1'b0);

        // Newest duplicate wins on a buffer hit
        push_line(23'h000030, {4{32'h3030_3030}});
        push_line(23'h000020, {4{32'h0D10_0D10}});
        push_line(23'h000020, {4{32'h0D20_0D20}});
        rd_req  = 1'b1;
        rd_addr = 23'h000020;
        check("t3 draining 0x30", mem_addr, 23'h000030);
        tick();
        check("t3 read waits", rd_done, 1'b0);
        mem_ready = 1'b1;
        tick();
        mem_ready = 1'b0;
        check("t3 idle rd_done", rd_done, 1'b0);
        tick();
        check("t3 rd_done", rd_done, 1'b1);
        check("t3 rd_data D2", rd_data, {4{32'h0D20_0D20}});
        check("t3 no rden", mem_rden, 1'b0);
        rd_req = 1'b0;
        tick();
        check("t3 rd_done pulse", rd_done, 1'b0);
        drain_one("t3 D1", 23'h000020, {4{32'h0D10_0D10}});
        drain_one("t3 D2", 23'h000020, {4{32'h0D20_0D20}});

        // Miss refill takes priority over pending drains
        push_line(23'h000041, {4{32'h4141_4141}});
        push_line(23'h000042, {4{32'h4242_4242}});
        push_line(23'h000043, {4{32'h4343_4343}});
        rd_req  = 1'b1;
        rd_addr = 23'h000055;
        check("t4 draining 0x41", mem_addr, 23'h000041);
        mem_ready = 1'b1;
        tick();
        mem_ready = 1'b0;
        tick();
        check("t4 rden", mem_rden, 1'b1);
        check("t4 wren low", mem_wren, 1'b0);
        check("t4 rd addr", mem_addr, 23'h000055);
        tick();
        check("t4 rden hold", mem_rden, 1'b1);
        mem_ready = 1'b1;
        mem_rdata = {4{32'h5555_CAFE}};
        tick();
        mem_ready = 1'b0;
        mem_rdata = '0;
        check("t4 rd_done", rd_done, 1'b1);
        check("t4 rd_data", rd_data, {4{32'h5555_CAFE}});
        check("t4 rden drop", mem_rden, 1'b0);
        rd_req = 1'b0;
        tick();
        drain_one("t4 b", 23'h000042, {4{32'h4242_4242}});
        drain_one("t4 c", 23'h000043, {4{32'h4343_4343}});

        // Same-cycle push and read of the same line
        rd_req  = 1'b1;
        rd_addr = 23'h000077;
        push_line(23'h000077, {4{32'h7777_BEEF}});
        check("t5 rd_done", rd_done, 1'b1);
        check("t5 rd_data", rd_data, {4{32'h7777_BEEF}});
        check("t5 no rden", mem_rden, 1'b0);
        rd_req = 1'b0;
        tick();
        drain_one("t5", 23'h000077, {4{32'h7777_BEEF}});

        // Reset during a drain write
        push_line(23'h000061, {4{32'h6161_6161}});
        push_line(23'h000062, {4{32'h6262_6262}});
        push_line(23'h000063, {4{32'h6363_6363}});
        check("t6 in WR_MEM", mem_wren, 1'b1);
        rst = 1'b1;
        #1;
        check("t6 full", full, 1'b0);
        check("t6 empty", empty, 1'b1);
        check("t6 rd_done", rd_done, 1'b0);
        check("t6 rd_data", rd_data, '0);
        check("t6 wren", mem_wren, 1'b0);
        check("t6 rden", mem_rden, 1'b0);
        check("t6 mem_addr", mem_addr, '0);
        check("t6 mem_data", mem_data, '0);
        tick();
        rst = 1'b0;
        for (int i = 0; i < 5; i++) begin
            tick();
            check($sformatf("t6 quiet %0d", i), {mem_wren, mem_rden, empty}, 3'b001);
        end

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/riscv_dcache_wb_buffer.md
# riscv_dcache_wb_buffer

Write-back buffer between the data-cache controller and the line-granular DRAM port. Dirty lines evicted by the cache are queued here instead of stalling on memory. Refill reads take priority over draining. Refill reads that match a queued line are served from the buffer, so the cache never reads stale memory.

## Interface
Parameters:
- AWIDTH, 23, line address width (tag + index; byte offset excluded)
- DWIDTH, 128, line width in bits
- DEPTH, 4, number of entries; power of two, ≥ 2

Ports:
- i_riscv_wbuf_clk  in  1  clock, all state updates on rising edge
- i_riscv_wbuf_rst  in  1  asynchronous, active-high reset
- i_riscv_wbuf_push  in  1  enqueue an evicted line this cycle
- i_riscv_wbuf_push_addr  in  AWIDTH  line address of evicted line
- i_riscv_wbuf_push_data  in  DWIDTH  evicted line data
- o_riscv_wbuf_full  out  1  count == DEPTH
- o_riscv_wbuf_empty  out  1  count == 0
- i_riscv_wbuf_rd_req  in  1  refill request, held until rd_done
- i_riscv_wbuf_rd_addr  in  AWIDTH  refill line address, stable while rd_req high
- o_riscv_wbuf_rd_data  out  DWIDTH  refill line, valid while rd_done high
- o_riscv_wbuf_rd_done  out  1  one-cycle completion pulse
- o_riscv_wbuf_mem_wren  out  1  DRAM line write
- o_riscv_wbuf_mem_rden  out  1  DRAM line read
- o_riscv_wbuf_mem_addr  out  AWIDTH  DRAM line address
- o_riscv_wbuf_mem_data  out  DWIDTH  DRAM write data
- i_riscv_wbuf_mem_ready  in  1  DRAM completion; read data on i_riscv_wbuf_mem_rdata this cycle
- i_riscv_wbuf_mem_rdata  in  DWIDTH  DRAM read data

## Operation
- Storage: circular FIFO of {addr, data}.
  - head/tail pointers are clog2(DEPTH) bits and wrap from DEPTH-1 to 0.
  - count is clog2(DEPTH+1) bits.
- Push:
  - Accepted in any state when push=1 and full=0; writes the tail entry and advances tail.
  - Push while full is ignored: contents and pointers unchanged.
  - Duplicate addresses are not coalesced. FIFO order guarantees DRAM ends with the newest copy.
- FSM states: IDLE, RD_MEM, WR_MEM, RD_DONE.
- IDLE, priority order:
  1. rd_req=1: search all valid entries plus any push accepted this same cycle. Newest matching entry wins.
     - Hit: latch that entry's data into rd_data and go to RD_DONE.
     - Miss: latch rd_addr into mem_addr and go to RD_MEM.
  2. Otherwise, if not empty: latch the head entry into mem_addr/mem_data and go to WR_MEM.
  3. Otherwise, stay in IDLE.
- RD_MEM:
  - mem_rden=1.
  - On mem_ready=1, capture i_riscv_wbuf_mem_rdata into rd_data and go to RD_DONE.
- WR_MEM:
  - mem_wren=1.
  - On mem_ready=1, pop the head and go to IDLE.
  - A push and a pop in the same cycle leave count unchanged.
- RD_DONE:
  - rd_done=1 for exactly one cycle, then go to IDLE.
  - rd_req is sampled again only in IDLE, so the requester drops it in the cycle after rd_done.
- mem_wren and mem_rden are never high together. mem_addr and mem_data stay stable for the whole transaction.
- mem_ready outside RD_MEM/WR_MEM is ignored.
- Reset (at any time, including mid-transaction):
  - State IDLE, pointers/count 0, all entries invalid.
  - Any in-flight DRAM transaction is abandoned.
  - Output values: full=0, empty=1, rd_done=0, rd_data=0, mem_wren=0, mem_rden=0, mem_addr=0, mem_data=0.

## Timing
- Buffer-hit refill: rd_req sampled in IDLE at edge N → rd_done high in cycle N+1.
- Miss refill: mem_rden high from cycle N+1 until the cycle with mem_ready (M) inclusive. rd_done high in M+1, mem_rden low in M+1.
- Drain: mem_wren high from the cycle after the IDLE decision through the mem_ready cycle M. State is IDLE in M+1; the next DRAM operation asserts no earlier than M+2.
- full/empty are decoded from registered count, so they update in the cycle after a push/pop edge.
- A read arriving during WR_MEM waits for that write to complete. Drain is not preempted.

## Test plan
- Reset, then push addr 0x000010 with data 0xA5…A5; no rd_req; mem_ready 3 cycles after wren rises → mem_wren/addr 0x000010/data match, empty=1 after pop.
- Push addrs 1, 2, 3, 4 back-to-back with DRAM stalled (mem_ready=0) → full=1 after 4th; 5th push ignored; drained DRAM order 1, 2, 3, 4, pointers wrap correctly.
- Push 0x000020/D1, then 0x000020/D2, then rd_req 0x000020 before drain → rd_done next cycle with D2, mem_rden never asserted.
- rd_req 0x000055 (not buffered) while buffer holds 2 entries and FSM is in IDLE → mem_rden issued before any mem_wren; rd_data equals DRAM data on the mem_ready cycle.
- rd_req and push of the same addr 0x000077 in the same IDLE cycle → buffer hit, rd_data = pushed data.
- Assert reset in the middle of a WR_MEM with 3 entries → all outputs return to reset values immediately; after release, no DRAM activity.
